// File: rtl/mix_columns_iter.sv
// mix_columns_iter: iterative AES MixColumns / InvMixColumns engine.
// Accepts one 128-bit column-major state per in_valid/in_ready handshake,
// transforms COLS_PER_CYCLE columns per clock in place, then holds the
// result on out_data with out_valid until out_ready is seen.
//
// Ports:
//   clk, rst_n          clock (rising edge), async active-low reset
//   in_valid/in_ready   input handshake; in_ready is high only in IDLE
//   in_data [127:0]     state, column c at [127-32c -: 32], byte r at [127-32c-8r -: 8]
//   in_inv              0 = MixColumns, 1 = InvMixColumns (latched at accept)
//   out_valid/out_ready output handshake
//   out_data [127:0]    working register; meaningful only while out_valid=1
//   busy                high in RUN or DONE
module mix_columns_iter #(
  parameter int unsigned COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic         in_inv,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  localparam int unsigned NUM_STEPS = 4 / COLS_PER_CYCLE;

  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
    $error("mix_columns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t       state;
  logic [1:0]   step;
  logic         mode;
  logic [127:0] work;
  logic [127:0] work_next;
  logic         in_ready_q;
  logic         out_valid_q;
  logic         busy_q;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiply one column by the forward or inverse matrix. The inverse
  // coefficients are composed from the x2/x4/x8 chain:
  //   9 = x8^1, B = x8^x2^1, D = x8^x4^1, E = x8^x4^x2.
  function automatic logic [31:0] mix_col(input logic [31:0] col, input logic inv);
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] m2 [4];
    logic [7:0] m3 [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] a  [4];
    logic [7:0] x4, x8;
    logic [31:0] res;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    a[0] = a0;
    a[1] = a1;
    a[2] = a2;
    a[3] = a3;
    for (int unsigned r = 0; r < 4; r++) begin
      m2[r] = xtime(a[r]);
      x4    = xtime(m2[r]);
      x8    = xtime(x4);
      m3[r] = m2[r] ^ a[r];
      m9[r] = x8 ^ a[r];
      mb[r] = x8 ^ m2[r] ^ a[r];
      md[r] = x8 ^ x4 ^ a[r];
      me[r] = x8 ^ x4 ^ m2[r];
    end
    if (inv) begin
      res[31:24] = me[0] ^ mb[1] ^ md[2] ^ m9[3];
      res[23:16] = m9[0] ^ me[1] ^ mb[2] ^ md[3];
      res[15:8]  = md[0] ^ m9[1] ^ me[2] ^ mb[3];
      res[7:0]   = mb[0] ^ md[1] ^ m9[2] ^ me[3];
    end else begin
      res[31:24] = m2[0] ^ m3[1] ^ a2    ^ a3;
      res[23:16] = a0    ^ m2[1] ^ m3[2] ^ a3;
      res[15:8]  = a0    ^ a1    ^ m2[2] ^ m3[3];
      res[7:0]   = m3[0] ^ a1    ^ a2    ^ m2[3];
    end
    return res;
  endfunction

  // Column g belongs to step g / COLS_PER_CYCLE; only that step rewrites it.
  for (genvar g = 0; g < 4; g++) begin : g_col
    logic [31:0] mixed;
    assign mixed = mix_col(work[127-32*g -: 32], mode);
    assign work_next[127-32*g -: 32] =
      (step == 2'(g / COLS_PER_CYCLE)) ? mixed : work[127-32*g -: 32];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      step        <= '0;
      mode        <= 1'b0;
      work        <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            work       <= in_data;
            mode       <= in_inv;
            step       <= '0;
            state      <= RUN;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        RUN: begin
          work <= work_next;
          if (step == 2'(NUM_STEPS - 1)) begin
            step        <= '0;
            state       <= DONE;
            out_valid_q <= 1'b1;
          end else begin
            step <= step + 2'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          step        <= '0;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign out_data  = work;

endmodule

// File: tb/tb_mix_columns_iter.sv
// tb_mix_columns_iter: self-checking bench for mix_columns_iter with three
// instances (COLS_PER_CYCLE = 1, 2, 4) sharing clock and reset.
module tb_mix_columns_iter;

  localparam int CPC [3] = '{1, 2, 4};

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid  [3];
  logic         in_ready  [3];
  logic [127:0] in_data   [3];
  logic         in_inv    [3];
  logic         out_valid [3];
  logic         out_ready [3];
  logic [127:0] out_data  [3];
  logic         busy      [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mix_columns_iter #(.COLS_PER_CYCLE(1)) u_c1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_data(in_data[0]), .in_inv(in_inv[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .out_data(out_data[0]), .busy(busy[0]));
  mix_columns_iter #(.COLS_PER_CYCLE(2)) u_c2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_data(in_data[1]), .in_inv(in_inv[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .out_data(out_data[1]), .busy(busy[1]));
  mix_columns_iter #(.COLS_PER_CYCLE(4)) u_c4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_data(in_data[2]), .in_inv(in_inv[2]), .out_valid(out_valid[2]),
    .out_ready(out_ready[2]), .out_data(out_data[2]), .busy(busy[2]));

  // Reference: generic GF(2^8) shift-and-add multiply and a circulant matrix product.
  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in;
    b = b_in;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
      b = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  function automatic logic [127:0] ref_mix(input logic [127:0] s, input logic inv);
    logic [7:0] row0 [4];
    logic [7:0] st [4][4];
    logic [7:0] o;
    logic [127:0] res;
    if (inv) begin
      row0[0] = 8'h0e; row0[1] = 8'h0b; row0[2] = 8'h0d; row0[3] = 8'h09;
    end else begin
      row0[0] = 8'h02; row0[1] = 8'h03; row0[2] = 8'h01; row0[3] = 8'h01;
    end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        st[c][r] = s[127-32*c-8*r -: 8];
    res = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        o = 8'h00;
        for (int k = 0; k < 4; k++) o = o ^ gmul(row0[(k - r + 4) % 4], st[c][k]);
        res[127-32*c-8*r -: 8] = o;
      end
    return res;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %h required %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual timeout required event", name);
  endtask

  // Wait for in_ready (checked at negedge), present one block, measure the
  // latency to out_valid, compare the result and complete the handshake.
  task automatic run_block(input int d, input logic [127:0] data, input logic inv,
                           input logic [127:0] exp, input string name);
    int lat;
    bit got;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (in_ready[d]) got = 1;
    end
    if (!got) begin
      timeout({name, "_ready"});
      return;
    end
    in_valid[d] = 1'b1;
    in_data[d]  = data;
    in_inv[d]   = inv;
    @(posedge clk);
    #1;
    in_valid[d] = 1'b0;
    in_data[d]  = rand128();
    check({name, "_busy"}, 128'(busy[d]), 128'(1));
    lat = 0;
    got = 0;
    while (lat < 20 && !got) begin
      @(posedge clk);
      #1;
      lat++;
      if (out_valid[d]) got = 1;
    end
    if (!got) begin
      timeout({name, "_valid"});
      return;
    end
    check({name, "_latency"}, 128'(lat), 128'(4 / CPC[d]));
    check({name, "_data"}, out_data[d], exp);
    out_ready[d] = 1'b1;
    @(posedge clk);
    #1;
    out_ready[d] = 1'b0;
    check({name, "_ready_after"}, 128'(in_ready[d]), 128'(1));
    check({name, "_valid_after"}, 128'(out_valid[d]), 128'(0));
  endtask

  typedef struct {
    int           d;
    logic [127:0] din;
    logic         inv;
    logic [127:0] exp;
    string        name;
  } vec_t;

  localparam logic [127:0] PLAIN_A = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] MIXED_A = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] MIXED_B = 128'h8e4da1bc_9fdc589d_d5d5d7d6_4d7ebdf8;
  localparam logic [127:0] PLAIN_B = 128'hdb135345_f20a225c_d4d4d4d5_2d26314c;

  initial begin
    vec_t tbl [$];
    logic [127:0] v1, v2, held;
    logic         i1, i2;
    logic [127:0] bvec [8];
    logic         binv [8];
    int           bi, bj, last_cyc;
    bit           got;

    for (int d = 0; d < 3; d++) begin
      in_valid[d]  = 1'b0;
      in_data[d]   = '0;
      in_inv[d]    = 1'b0;
      out_ready[d] = 1'b0;
    end

    // Reset state
    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check($sformatf("rst_in_ready%0d", d), 128'(in_ready[d]), 128'(1));
      check($sformatf("rst_out_valid%0d", d), 128'(out_valid[d]), 128'(0));
      check($sformatf("rst_busy%0d", d), 128'(busy[d]), 128'(0));
      check($sformatf("rst_out_data%0d", d), out_data[d], 128'(0));
    end
    rst_n = 1'b1;

    // Directed vectors
    tbl.push_back('{0, PLAIN_A, 1'b0, MIXED_A, "fwd_c1"});
    tbl.push_back('{1, PLAIN_A, 1'b0, MIXED_A, "fwd_c2"});
    tbl.push_back('{2, PLAIN_A, 1'b0, MIXED_A, "fwd_c4"});
    tbl.push_back('{0, MIXED_B, 1'b1, PLAIN_B, "inv_c1"});
    tbl.push_back('{1, MIXED_B, 1'b1, PLAIN_B, "inv_c2"});
    tbl.push_back('{2, MIXED_B, 1'b1, PLAIN_B, "inv_c4"});
    foreach (tbl[i]) run_block(tbl[i].d, tbl[i].din, tbl[i].inv, tbl[i].exp, tbl[i].name);

    // Randomized blocks against the reference model
    for (int d = 0; d < 3; d++)
      for (int k = 0; k < 6; k++) begin
        v1 = rand128();
        i1 = 1'($urandom_range(0, 1));
        run_block(d, v1, i1, ref_mix(v1, i1), $sformatf("rand_c%0d_%0d", CPC[d], k));
      end

    // Round trip: forward then inverse must return the original
    v1 = rand128();
    run_block(1, ref_mix(v1, 1'b0), 1'b1, v1, "roundtrip_c2");

    // Mode latching: in_inv and in_data wiggle during RUN
    @(negedge clk);
    in_valid[0] = 1'b1; in_data[0] = PLAIN_A; in_inv[0] = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      in_inv[0]   = ~in_inv[0];
      in_valid[0] = 1'b1;
      in_data[0]  = rand128();
      @(posedge clk); #1;
    end
    in_valid[0] = 1'b0;
    check("latch_valid", 128'(out_valid[0]), 128'(1));
    check("latch_data", out_data[0], MIXED_A);
    out_ready[0] = 1'b1;
    @(posedge clk); #1;
    out_ready[0] = 1'b0;

    // Backpressure: result held, second block refused until after handshake
    v1 = rand128(); i1 = 1'($urandom_range(0, 1));
    v2 = rand128(); i2 = 1'($urandom_range(0, 1));
    @(negedge clk);
    in_valid[0] = 1'b1; in_data[0] = v1; in_inv[0] = i1;
    @(posedge clk); #1;
    in_data[0] = v2; in_inv[0] = i2;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk); #1;
      if (out_valid[0]) got = 1;
    end
    if (!got) timeout("bp_valid");
    held = out_data[0];
    check("bp_first", held, ref_mix(v1, i1));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("bp_stable%0d", i), out_data[0], held);
      check($sformatf("bp_in_ready%0d", i), 128'(in_ready[0]), 128'(0));
    end
    out_ready[0] = 1'b1;
    @(posedge clk); #1;
    out_ready[0] = 1'b0;
    check("bp_idle_ready", 128'(in_ready[0]), 128'(1));
    check("bp_not_taken", 128'(busy[0]), 128'(0));
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    check("bp_second_taken", 128'(busy[0]), 128'(1));
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk); #1;
      if (out_valid[0]) got = 1;
    end
    if (!got) timeout("bp_second_valid");
    check("bp_second", out_data[0], ref_mix(v2, i2));
    out_ready[0] = 1'b1;
    @(posedge clk); #1;
    out_ready[0] = 1'b0;

    // Reset in the middle of a C=1 run, at step 2
    @(negedge clk);
    in_valid[0] = 1'b1; in_data[0] = PLAIN_A; in_inv[0] = 1'b0;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 128'(out_valid[0]), 128'(0));
    check("midrst_in_ready", 128'(in_ready[0]), 128'(1));
    check("midrst_out_data", out_data[0], 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    run_block(0, 128'hd4d4d4d5_f20a225c_01010101_c6c6c6c6, 1'b0,
              128'hd5d5d7d6_9fdc589d_01010101_c6c6c6c6, "after_rst");

    // Back-to-back on C=4 with continuous valid/ready
    for (int i = 0; i < 8; i++) begin
      bvec[i] = rand128();
      binv[i] = 1'($urandom_range(0, 1));
    end
    bi = 0; bj = 0; last_cyc = 0;
    out_ready[2] = 1'b1;
    for (int cyc = 0; cyc < 120 && bj < 8; cyc++) begin
      @(negedge clk);
      if (out_valid[2]) begin
        check($sformatf("b2b_data%0d", bj), out_data[2], ref_mix(bvec[bj], binv[bj]));
        if (bj > 0) check($sformatf("b2b_gap%0d", bj), 128'(cyc - last_cyc), 128'(3));
        last_cyc = cyc;
        bj++;
      end
      if (bi < 8) begin
        in_valid[2] = 1'b1;
        in_data[2]  = bvec[bi];
        in_inv[2]   = binv[bi];
        if (in_ready[2]) bi++;
      end else begin
        in_valid[2] = 1'b0;
      end
    end
    in_valid[2]  = 1'b0;
    out_ready[2] = 1'b0;
    if (bj != 8) timeout("b2b_count");

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
